// File: rtl/tim1_sr_irq_if.sv
// Bus between the timer core and the status/interrupt block.
// Event, write and acknowledge strobes are single-cycle pulses sampled on the rising edge; enables are levels.
interface tim1_sr_irq_if;
    logic       ev_update;
    logic       ev_cc1;
    logic       wr_sr;
    logic [2:0] i_sr_wdata;
    logic       i_uie;
    logic       i_cc1ie;
    logic       i_irq_ack;
    logic [2:0] o_sr;
    logic       o_irq;
    logic [1:0] o_state;

    modport slave (
        input  ev_update, ev_cc1, wr_sr, i_sr_wdata, i_uie, i_cc1ie, i_irq_ack,
        output o_sr, o_irq, o_state
    );

    modport master (
        output ev_update, ev_cc1, wr_sr, i_sr_wdata, i_uie, i_cc1ie, i_irq_ack,
        input  o_sr, o_irq, o_state
    );
endinterface

// File: rtl/tim1_sr_irq.sv
// TIM1 status register {CC1OF, CC1IF, UIF} with rc_w0 clears and a registered
// interrupt request driven by an IDLE/PEND/SERVICE handshake with the interrupt controller.
module tim1_sr_irq (
    input  logic          clk,
    input  logic          rst,
    tim1_sr_irq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sr_q, sr_d;
    logic       irq_q, irq_d;
    logic [2:0] sw_clr;
    logic       pending;
    logic       new_evt;

    // Hardware set wins over a same-cycle software clear; CC1OF looks at pre-edge CC1IF.
    always_comb begin
        sw_clr  = {3{bus.wr_sr}} & ~bus.i_sr_wdata;
        sr_d[0] = bus.ev_update | (sr_q[0] & ~sw_clr[0]);
        sr_d[1] = bus.ev_cc1    | (sr_q[1] & ~sw_clr[1]);
        sr_d[2] = (bus.ev_cc1 & sr_q[1]) | (sr_q[2] & ~sw_clr[2]);
        pending = (sr_q[0] & bus.i_uie) | (sr_q[1] & bus.i_cc1ie);
        new_evt = (bus.ev_update & bus.i_uie) | (bus.ev_cc1 & bus.i_cc1ie);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= 3'b000;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                state_d = pending ? ST_PEND : ST_IDLE;
            end
            ST_PEND: begin
                if (bus.i_irq_ack) state_d = ST_SERVICE;
                else if (!pending) state_d = ST_IDLE;
                else               state_d = ST_PEND;
            end
            ST_SERVICE: begin
                if (new_evt)       state_d = ST_PEND;
                else if (!pending) state_d = ST_IDLE;
                else               state_d = ST_SERVICE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is registered alongside the state so it never glitches.
    always_comb begin
        irq_d = (state_d == ST_PEND);
    end

    assign bus.o_sr    = sr_q;
    assign bus.o_irq   = irq_q;
    assign bus.o_state = state_q;
endmodule

// File: tb/tb_tim1_sr_irq.sv
// Bench for tim1_sr_irq: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a rule-level model of flags and request.
module tb_tim1_sr_irq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    tim1_sr_irq_if bus_if ();

    tim1_sr_irq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Reference model: flags as a bit set, handshake phase as 0 idle / 1 pending / 2 in service.
    logic [2:0] m_sr    = 3'b000;
    int         m_phase = 0;

    function automatic logic [2:0] model_flags(input logic [2:0] fl, input logic ev_u, input logic ev_c,
                                               input logic wr, input logic [2:0] wd);
        logic [2:0] r;
        r = fl;
        if (wr) begin
            for (int i = 0; i < 3; i++) if (!wd[i]) r[i] = 1'b0;
        end
        if (ev_u) r[0] = 1'b1;
        if (ev_c) begin
            r[1] = 1'b1;
            if (fl[1]) r[2] = 1'b1;
        end
        return r;
    endfunction

    function automatic int model_phase(input int ph, input logic [2:0] fl, input logic uie, input logic cc1ie,
                                       input logic ev_u, input logic ev_c, input logic ack);
        logic req;
        req = (fl[0] && uie) || (fl[1] && cc1ie);
        if (ph == 1 && ack) return 2;
        if (ph == 2 && ((ev_u && uie) || (ev_c && cc1ie))) return 1;
        if (!req) return 0;
        return (ph == 0) ? 1 : ph;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sr    <= 3'b000;
            m_phase <= 0;
        end else begin
            m_sr    <= model_flags(m_sr, bus_if.ev_update, bus_if.ev_cc1, bus_if.wr_sr, bus_if.i_sr_wdata);
            m_phase <= model_phase(m_phase, m_sr, bus_if.i_uie, bus_if.i_cc1ie,
                                   bus_if.ev_update, bus_if.ev_cc1, bus_if.i_irq_ack);
        end
    end

    always @(negedge clk) begin
        check("sr_vs_model",    {29'd0, bus_if.o_sr},    {29'd0, m_sr});
        check("irq_vs_model",   {31'd0, bus_if.o_irq},   (m_phase == 1) ? 32'd1 : 32'd0);
        check("state_vs_model", {30'd0, bus_if.o_state}, m_phase);
    end

    task automatic step(input logic u, input logic c, input logic w, input logic [2:0] wd, input logic a);
        bus_if.ev_update  = u;
        bus_if.ev_cc1     = c;
        bus_if.wr_sr      = w;
        bus_if.i_sr_wdata = wd;
        bus_if.i_irq_ack  = a;
        @(posedge clk);
        #1;
        bus_if.ev_update  = 1'b0;
        bus_if.ev_cc1     = 1'b0;
        bus_if.wr_sr      = 1'b0;
        bus_if.i_irq_ack  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus_if.ev_update  = 1'b0;
        bus_if.ev_cc1     = 1'b0;
        bus_if.wr_sr      = 1'b0;
        bus_if.i_sr_wdata = 3'b111;
        bus_if.i_uie      = 1'b0;
        bus_if.i_cc1ie    = 1'b0;
        bus_if.i_irq_ack  = 1'b0;
        #1;
        check("reset_sr",    {29'd0, bus_if.o_sr},    32'd0);
        check("reset_irq",   {31'd0, bus_if.o_irq},   32'd0);
        check("reset_state", {30'd0, bus_if.o_state}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Update event through the full handshake.
        bus_if.i_uie = 1'b1;
        step(1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        check("upd_flag_1edge", {29'd0, bus_if.o_sr},  32'd1);
        check("upd_irq_1edge",  {31'd0, bus_if.o_irq}, 32'd0);
        idle(1);
        check("upd_irq_2edge",  {31'd0, bus_if.o_irq},   32'd1);
        check("upd_state_pend", {30'd0, bus_if.o_state}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        check("ack_irq",        {31'd0, bus_if.o_irq},   32'd0);
        check("ack_state_svc",  {30'd0, bus_if.o_state}, 32'd2);
        step(1'b0, 1'b0, 1'b1, 3'b110, 1'b0);
        check("clr_uif",        {29'd0, bus_if.o_sr},    32'd0);
        idle(1);
        check("svc_to_idle",    {30'd0, bus_if.o_state}, 32'd0);

        // Missed capture, then clear all with rc_w0.
        bus_if.i_uie = 1'b0;
        step(1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
        check("cc1_first",   {29'd0, bus_if.o_sr}, 32'd2);
        step(1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
        check("cc1_overrun", {29'd0, bus_if.o_sr}, 32'd6);
        step(1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
        check("cc1_cleared", {29'd0, bus_if.o_sr}, 32'd0);

        // Set beats a simultaneous clear.
        step(1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
        check("set_beats_clr", {29'd0, bus_if.o_sr}, 32'd1);
        // Overrun uses pre-edge CC1IF even when it is being cleared.
        step(1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'b101, 1'b0);
        check("ovr_pre_edge", {29'd0, bus_if.o_sr}, 32'd7);
        step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        check("clr_all", {29'd0, bus_if.o_sr}, 32'd0);

        // Masked flag, enable raised later.
        step(1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        idle(1);
        check("masked_flag", {29'd0, bus_if.o_sr},  32'd1);
        check("masked_irq",  {31'd0, bus_if.o_irq}, 32'd0);
        bus_if.i_uie = 1'b1;
        idle(2);
        check("unmask_irq",  {31'd0, bus_if.o_irq}, 32'd1);
        // Withdrawing the enable while pending drops the request.
        bus_if.i_uie = 1'b0;
        idle(1);
        check("withdraw_state", {30'd0, bus_if.o_state}, 32'd0);
        check("withdraw_irq",   {31'd0, bus_if.o_irq},   32'd0);

        // New enabled event while in service re-requests.
        bus_if.i_uie   = 1'b1;
        bus_if.i_cc1ie = 1'b1;
        idle(1);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
        check("svc_again", {30'd0, bus_if.o_state}, 32'd2);
        step(1'b0, 1'b1, 1'b0, 3'b111, 1'b0);
        check("svc_repend_state", {30'd0, bus_if.o_state}, 32'd1);
        check("svc_repend_irq",   {31'd0, bus_if.o_irq},   32'd1);

        // Asynchronous reset while pending.
        #2 rst = 1'b1;
        #1;
        check("rst_irq",   {31'd0, bus_if.o_irq},   32'd0);
        check("rst_sr",    {29'd0, bus_if.o_sr},    32'd0);
        check("rst_state", {30'd0, bus_if.o_state}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        check("post_rst_idle", {30'd0, bus_if.o_state}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bus_if.i_uie   = ~bus_if.i_uie;
            if ($urandom_range(0, 7) == 0) bus_if.i_cc1ie = ~bus_if.i_cc1ie;
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2) == 0);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tim1_sr_irq.md
TIM1_SR_IRQ -- requirements
Module: tim1_sr_irq

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-003 SHALL have port ev_update, input, 1, counter update/overflow event, 1-cycle pulse.
REQ-004 SHALL have port ev_cc1, input, 1, capture/compare channel 1 event, 1-cycle pulse.
REQ-005 SHALL have port wr_sr, input, 1, software write strobe to status register, 1 cycle.
REQ-006 SHALL have port i_sr_wdata, input, 3, write data {CC1OF, CC1IF, UIF}; rc_w0 semantics.
REQ-007 SHALL have port i_uie, input, 1, update interrupt enable from the interrupt-enable register.
REQ-008 SHALL have port i_cc1ie, input, 1, CC1 interrupt enable from the interrupt-enable register.
REQ-009 SHALL have port i_irq_ack, input, 1, interrupt controller acknowledge, 1-cycle pulse.
REQ-010 SHALL have port o_sr, output, 3, status flags {CC1OF, CC1IF, UIF}.
REQ-011 SHALL have port o_irq, output, 1, registered interrupt request to interrupt controller.
REQ-012 SHALL have port o_state, output, 2, FSM state encoding for debug (IDLE=0, PEND=1, SERVICE=2).

Function
REQ-013 SHALL set UIF on the clock edge following ev_update=1.
REQ-014 SHALL set CC1IF on the clock edge following ev_cc1=1.
REQ-015 SHALL set CC1OF when ev_cc1=1 while CC1IF is already 1 (missed capture).
REQ-016 SHALL, on wr_sr=1, clear each flag whose i_sr_wdata bit is 0; a written 1 leaves that flag unchanged.
REQ-017 SHALL give hardware set priority over a software clear of the same flag in the same cycle (flag ends 1).
REQ-018 SHALL evaluate CC1OF with the pre-edge CC1IF value: ev_cc1 with wr_sr clearing CC1IF in the same cycle sets CC1OF if CC1IF was 1.
REQ-019 SHALL form pending = (UIF & i_uie) | (CC1IF & i_cc1ie); CC1OF alone does not request.
REQ-020 SHALL implement FSM IDLE: o_irq=0; pending=1 -> PEND next edge.
REQ-021 SHALL implement FSM PEND: o_irq=1; i_irq_ack=1 -> SERVICE; pending drops to 0 without ack -> IDLE (withdrawn request).
REQ-022 SHALL implement FSM SERVICE: o_irq=0; any new flag-setting event on an enabled source (ev_update&i_uie or ev_cc1&i_cc1ie) -> PEND; else pending=0 -> IDLE; else stay.
REQ-023 SHALL ignore i_irq_ack in IDLE and SERVICE.
REQ-024 SHALL register o_irq from FSM state; latency event-to-o_irq = 2 clock edges (flag edge, then PEND edge).
REQ-025 SHALL treat enable changes live: clearing i_uie/i_cc1ie while in PEND with no other pending source returns to IDLE next edge.
REQ-026 SHALL map any unused state encoding to IDLE on the next edge.

Reset
REQ-027 SHALL, while rst=1, force o_sr=3'b000, o_irq=0, FSM=IDLE, independent of clk.
REQ-028 SHALL, on rst asserted mid-PEND or mid-SERVICE, drop o_irq the same instant and discard in-flight events.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-030 SHALL verify: i_uie=1, ev_update pulse -> o_sr=3'b001 after 1 edge, o_irq=1 after 2 edges; i_irq_ack -> o_irq=0, state SERVICE; wr_sr with wdata=3'b110 -> UIF=0, state IDLE next edge.
REQ-031 SHALL verify: two ev_cc1 pulses without clear -> o_sr=3'b110; wr_sr wdata=3'b001 -> o_sr=3'b000.
REQ-032 SHALL verify: ev_update and wr_sr wdata=3'b110 same cycle with UIF=1 -> UIF stays 1.
REQ-033 SHALL verify: i_uie=0, ev_update -> UIF=1, o_irq stays 0; then i_uie=1 -> o_irq=1 two edges later.
REQ-034 SHALL verify: in SERVICE with UIF still set, ev_cc1 with i_cc1ie=1 -> PEND, o_irq=1 again.
REQ-035 SHALL verify: rst pulse during PEND -> o_irq=0 and o_sr=3'b000 immediately, state IDLE.
